// File: rtl/vec3_product_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vec3_product_pipe                                               |
// | Brief    : Pipelined cross / dot / component-wise float3 product engine     |
// |            with tagged results and a credit-tracked show-ahead output FIFO. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+

package vec3_product_pipe_pkg;
   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] z;
   } p_float3;
endpackage

module vec3_product_pipe
   import vec3_product_pipe_pkg::*;
#(
   parameter int MULT_LAT   = 4,
   parameter int ADD_LAT    = 5,
   parameter int FIFO_DEPTH = 16,
   parameter int TAG_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_mode,
   input  p_float3          in_a,
   input  p_float3          in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output p_float3          out_c,
   output logic [1:0]       out_mode,
   output logic [TAG_W-1:0] out_tag
);

   localparam int L  = MULT_LAT + 2*ADD_LAT;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int FW = 96 + 2 + TAG_W;
   localparam logic [CW-1:0] c_DEPTH      = CW'(FIFO_DEPTH);
   localparam logic [1:0]    c_MODE_CROSS = 2'd0;
   localparam logic [1:0]    c_MODE_DOT   = 2'd1;
   localparam logic [1:0]    c_MODE_CW    = 2'd2;

   // Single-precision multiply, round-to-nearest-even, denormals flushed to zero.
   function automatic logic [31:0] f_mul(input logic [31:0] a, input logic [31:0] b);
      logic        s, g, st;
      logic [47:0] p;
      logic [9:0]  e;
      logic [23:0] mr;
      s = a[31] ^ b[31];
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
      if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {s, 8'hFF, 23'd0};
      p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
      e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
      if (p[47]) begin
         mr = {1'b0, p[46:24]};
         g  = p[23];
         st = |p[22:0];
         e  = e + 10'd1;
      end else begin
         mr = {1'b0, p[45:23]};
         g  = p[22];
         st = |p[21:0];
      end
      if (g && (st || mr[0])) mr = mr + 24'd1;
      if (mr[23]) e = e + 10'd1;
      if (e[9] || e == 10'd0) return {s, 31'd0};
      if (e >= 10'd255) return {s, 8'hFF, 23'd0};
      return {s, e[7:0], mr[22:0]};
   endfunction

   // Single-precision add with the same rounding and flush behaviour; exact cancellation gives +0.
   function automatic logic [31:0] f_add(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x, y;
      logic [7:0]  d;
      logic [50:0] mx, my, sum, norm;
      logic [5:0]  pos;
      logic [9:0]  e;
      logic [23:0] mr;
      logic        g, st;
      if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return {a[31] & b[31], 31'd0};
      if (a[30:23] == 8'd0) return b;
      if (b[30:23] == 8'd0) return a;
      if (a[30:23] == 8'hFF) return a;
      if (b[30:23] == 8'hFF) return b;
      if (a[30:0] >= b[30:0]) begin
         x = a;
         y = b;
      end else begin
         x = b;
         y = a;
      end
      d  = x[30:23] - y[30:23];
      mx = {1'b0, 1'b1, x[22:0], 26'd0};
      // Beyond 26 places only a sticky bit of the smaller operand survives.
      if (d > 8'd26) my = 51'd1;
      else           my = {1'b0, 1'b1, y[22:0], 26'd0} >> d;
      sum = (x[31] ^ y[31]) ? (mx - my) : (mx + my);
      if (sum == 51'd0) return 32'd0;
      pos = 6'd0;
      for (int i = 0; i < 51; i++) if (sum[i]) pos = 6'(i);
      norm = sum << (6'd50 - pos);
      e    = {2'b00, x[30:23]} + {4'd0, pos} - 10'd49;
      mr   = {1'b0, norm[49:27]};
      g    = norm[26];
      st   = |norm[25:0];
      if (g && (st || mr[0])) mr = mr + 24'd1;
      if (mr[23]) e = e + 10'd1;
      if (e[9] || e == 10'd0) return {x[31], 31'd0};
      if (e >= 10'd255) return {x[31], 8'hFF, 23'd0};
      return {x[31], e[7:0], mr[22:0]};
   endfunction

   function automatic logic [31:0] f_neg(input logic [31:0] a);
      return {~a[31], a[30:0]};
   endfunction

   logic                          w_accept, w_pop, w_wr;
   logic [5:0][31:0]              w_ma, w_mb, w_prod;
   logic [MULT_LAT-1:0][5:0][31:0] r_m;
   logic [5:0][31:0]              w_p;
   logic [1:0]                    w_a1_mode, w_a2_mode;
   logic [31:0]                   w_s0, w_s1, w_s2, w_sum2;
   logic [2:0][31:0]              w_a1;
   logic [ADD_LAT-1:0][2:0][31:0] r_a1;
   logic [2:0][31:0]              w_v;
   p_float3                       w_a2;
   p_float3 [ADD_LAT-1:0]         r_a2;
   logic [L-1:0]                  r_sb_v;
   logic [L-1:0][1:0]             r_sb_mode;
   logic [L-1:0][TAG_W-1:0]       r_sb_tag;
   logic [FW-1:0]                 r_mem [FIFO_DEPTH];
   logic [FW-1:0]                 w_head, w_wdata;
   logic [CW-1:0]                 r_wptr, r_rptr, r_cnt;

   assign w_accept = in_valid && in_ready;
   assign in_ready = (r_cnt < c_DEPTH) && !rst;

   // Issue: operands routed to the six multipliers according to the incoming mode.
   always_comb begin
      w_ma    = '0;
      w_mb    = '0;
      w_ma[0] = in_a.x;  w_mb[0] = in_b.x;
      w_ma[1] = in_a.y;  w_mb[1] = in_b.y;
      w_ma[2] = in_a.z;  w_mb[2] = in_b.z;
      if (in_mode == c_MODE_CROSS) begin
         w_ma[0] = in_a.y;  w_mb[0] = in_b.z;
         w_ma[1] = in_a.z;  w_mb[1] = in_b.y;
         w_ma[2] = in_a.z;  w_mb[2] = in_b.x;
         w_ma[3] = in_a.x;  w_mb[3] = in_b.z;
         w_ma[4] = in_a.x;  w_mb[4] = in_b.y;
         w_ma[5] = in_a.y;  w_mb[5] = in_b.x;
      end
      for (int i = 0; i < 6; i++) w_prod[i] = f_mul(w_ma[i], w_mb[i]);
   end

   assign w_p       = r_m[MULT_LAT-1];
   assign w_a1_mode = r_sb_mode[MULT_LAT-1];
   assign w_s0      = f_add(w_p[0], (w_a1_mode == c_MODE_CROSS) ? f_neg(w_p[1]) : w_p[1]);
   assign w_s1      = f_add(w_p[2], f_neg(w_p[3]));
   assign w_s2      = f_add(w_p[4], f_neg(w_p[5]));

   // A1 lanes: cross differences, dot partial sum plus bypassed z product, or raw products.
   always_comb begin
      w_a1[0] = w_p[0];
      w_a1[1] = w_p[1];
      w_a1[2] = w_p[2];
      case (w_a1_mode)
         c_MODE_CROSS: begin
            w_a1[0] = w_s0;
            w_a1[1] = w_s1;
            w_a1[2] = w_s2;
         end
         c_MODE_DOT: begin
            w_a1[0] = w_s0;
            w_a1[1] = w_p[2];
            w_a1[2] = '0;
         end
         default: ;
      endcase
   end

   assign w_v       = r_a1[ADD_LAT-1];
   assign w_a2_mode = r_sb_mode[MULT_LAT+ADD_LAT-1];
   assign w_sum2    = f_add(w_v[0], w_v[1]);

   always_comb begin
      w_a2 = '0;
      case (w_a2_mode)
         c_MODE_CROSS, c_MODE_CW: begin
            w_a2.x = w_v[0];
            w_a2.y = w_v[1];
            w_a2.z = w_v[2];
         end
         c_MODE_DOT: w_a2.x = w_sum2;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      r_m[0]  <= w_prod;
      r_a1[0] <= w_a1;
      r_a2[0] <= w_a2;
      for (int i = 1; i < MULT_LAT; i++) r_m[i] <= r_m[i-1];
      for (int i = 1; i < ADD_LAT; i++) begin
         r_a1[i] <= r_a1[i-1];
         r_a2[i] <= r_a2[i-1];
      end
      r_sb_mode <= {r_sb_mode[L-2:0], in_mode};
      r_sb_tag  <= {r_sb_tag[L-2:0], in_tag};
      if (rst) r_sb_v <= '0;
      else     r_sb_v <= {r_sb_v[L-2:0], w_accept};
   end

   // Output FIFO; the credit count guarantees a write never meets a full buffer.
   assign w_wr      = r_sb_v[L-1];
   assign w_wdata   = {r_a2[ADD_LAT-1], r_sb_mode[L-1], r_sb_tag[L-1]};
   assign out_valid = (r_wptr != r_rptr);
   assign w_pop     = out_valid && out_ready;
   assign w_head    = r_mem[r_rptr[AW-1:0]];
   assign out_c     = out_valid ? p_float3'(w_head[FW-1:TAG_W+2]) : '0;
   assign out_mode  = out_valid ? w_head[TAG_W+1:TAG_W] : 2'd0;
   assign out_tag   = out_valid ? w_head[TAG_W-1:0] : '0;

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr[AW-1:0]] <= w_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_wr)  r_wptr <= r_wptr + 1'b1;
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         case ({w_accept, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vec3_product_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vec3_product_pipe                                            |
// | Brief    : Directed, table-driven bench for vec3_product_pipe.             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_vec3_product_pipe;
   import vec3_product_pipe_pkg::*;

   localparam int MULT_LAT = 4;
   localparam int ADD_LAT  = 5;
   localparam int DEPTH    = 16;
   localparam int TAG_W    = 8;
   localparam int L        = MULT_LAT + 2*ADD_LAT;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [1:0]       in_mode = 2'd0;
   p_float3          in_a = '0;
   p_float3          in_b = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   p_float3          out_c;
   logic [1:0]       out_mode;
   logic [TAG_W-1:0] out_tag;

   always #5 clk = ~clk;

   vec3_product_pipe #(
      .MULT_LAT(MULT_LAT), .ADD_LAT(ADD_LAT), .FIFO_DEPTH(DEPTH), .TAG_W(TAG_W)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_c(out_c), .out_mode(out_mode), .out_tag(out_tag)
   );

   typedef struct {
      logic [1:0]       mode;
      p_float3          a;
      p_float3          b;
      logic [TAG_W-1:0] tag;
      p_float3          exp_c;
   } vec_t;

   typedef struct {
      p_float3          c;
      logic [1:0]       mode;
      logic [TAG_W-1:0] tag;
      int               cyc;
   } obs_t;

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   obs_t q[$];
   vec_t tbl[$];

   // Exact integer to single-precision conversion for |v| < 2^24.
   function automatic logic [31:0] i2f(input int v);
      logic [31:0] m;
      int          p;
      logic        s;
      if (v == 0) return 32'd0;
      s = (v < 0);
      m = s ? -v : v;
      p = 0;
      for (int i = 0; i < 24; i++) if (m[i]) p = i;
      return {s, 8'(127 + p), 23'(m << (23 - p))};
   endfunction

   function automatic p_float3 f3(input int x, input int y, input int z);
      return '{i2f(x), i2f(y), i2f(z)};
   endfunction

   function automatic p_float3 model(input logic [1:0] m, input int a[3], input int b[3]);
      case (m)
         2'd0:    return f3(a[1]*b[2] - a[2]*b[1], a[2]*b[0] - a[0]*b[2], a[0]*b[1] - a[1]*b[0]);
         2'd1:    return f3(a[0]*b[0] + a[1]*b[1] + a[2]*b[2], 0, 0);
         2'd2:    return f3(a[0]*b[0], a[1]*b[1], a[2]*b[2]);
         default: return '0;
      endcase
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (!rst && out_valid && out_ready)
         q.push_back('{c: out_c, mode: out_mode, tag: out_tag, cyc: cyc});
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] m, input p_float3 a, input p_float3 b, input logic [TAG_W-1:0] t);
      in_valid = 1'b1;
      in_mode  = m;
      in_a     = a;
      in_b     = b;
      in_tag   = t;
   endtask

   task automatic wait_q(input int n, input int budget, input string name);
      int k = 0;
      while (q.size() < n && k < budget) begin
         step();
         k++;
      end
      check(name, q.size(), n);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int acc;
      int k;
      bit ok;
      bit rdy;

      // Vector table: hand-computed entries followed by a mixed-mode stream.
      tbl.push_back('{2'd1, f3(1,2,3), f3(4,5,6), 8'h21, '{32'h42000000, 32'h0, 32'h0}});
      tbl.push_back('{2'd2, f3(1,2,3), f3(4,5,6), 8'h22, '{32'h40800000, 32'h41200000, 32'h41900000}});
      tbl.push_back('{2'd3, f3(1,2,3), f3(4,5,6), 8'h23, '{32'h0, 32'h0, 32'h0}});
      tbl.push_back('{2'd2, '{32'h3FC00000, 32'hC0000000, 32'h3F000000},
                      '{32'h3FC00000, 32'h40400000, 32'hC0800000}, 8'h24,
                      '{32'h40100000, 32'hC0C00000, 32'hC0000000}});
      tbl.push_back('{2'd0, f3(1,2,3), f3(4,5,6), 8'h25, '{32'hC0400000, 32'h40C00000, 32'hC0400000}});
      for (int i = 0; i < 3*L; i++) begin
         int av[3];
         int bv[3];
         vec_t v;
         for (int j = 0; j < 3; j++) begin
            av[j] = int'($urandom_range(1, 9));
            bv[j] = int'($urandom_range(1, 9));
            if ($urandom_range(0, 1) == 1) av[j] = -av[j];
            if ($urandom_range(0, 1) == 1) bv[j] = -bv[j];
         end
         v.mode  = 2'(i % 3);
         v.a     = f3(av[0], av[1], av[2]);
         v.b     = f3(bv[0], bv[1], bv[2]);
         v.tag   = 8'(8'h40 + i);
         v.exp_c = model(v.mode, av, bv);
         tbl.push_back(v);
      end

      // Reset state
      repeat (3) step();
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_outputs", {out_valid, out_c, out_mode, out_tag}, '0);
      rst = 1'b0;
      #1;
      check("in_ready_after_rst", in_ready, 1'b1);

      // Single cross product: latency and content
      drive(2'd0, f3(1,0,0), f3(0,1,0), 8'h5A);
      step();
      in_valid = 1'b0;
      k = 1;
      while (!out_valid && k < L + 10) begin
         step();
         k++;
      end
      check("latency", k, L + 1);
      check("cross_unit", {out_c, out_mode, out_tag}, {f3(0,0,1), 2'd0, 8'h5A});
      out_ready = 1'b1;
      step();
      check("empty_after_pop", out_valid, 1'b0);
      q.delete();

      // Table vectors back to back
      foreach (tbl[i]) begin
         drive(tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].tag);
         step();
      end
      in_valid = 1'b0;
      wait_q(tbl.size(), L + 20, "table_count");
      for (int i = 0; i < q.size() && i < tbl.size(); i++)
         check($sformatf("vec%0d", i), {q[i].c, q[i].mode, q[i].tag},
               {tbl[i].exp_c, tbl[i].mode, tbl[i].tag});
      if (q.size() > 0)
         check("table_consecutive", q[q.size()-1].cyc - q[0].cyc, q.size() - 1);
      q.delete();

      // Backpressure: exactly DEPTH accepts with the consumer stalled
      out_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 40; i++) begin
         drive(2'd2, f3(i+1, 2, 3), f3(1, 1, 1), 8'(acc));
         rdy = in_ready;
         step();
         if (rdy) acc++;
      end
      in_valid = 1'b0;
      check("bp_accepts", acc, DEPTH);
      check("bp_full_ready", in_ready, 1'b0);
      out_ready = 1'b1;
      step();
      check("bp_reassert", in_ready, 1'b1);
      wait_q(DEPTH, DEPTH + 10, "bp_count");
      repeat (4) step();
      check("bp_no_dup", q.size(), DEPTH);
      for (int i = 0; i < q.size() && i < DEPTH; i++)
         check($sformatf("bp_tag%0d", i), q[i].tag, 8'(i));
      q.delete();

      // Reset with 3 buffered and 5 in flight
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(2'd1, f3(1,1,1), f3(1,1,1), 8'(8'h80 + i));
         step();
      end
      in_valid = 1'b0;
      repeat (L + 2) step();
      for (int i = 0; i < 5; i++) begin
         drive(2'd0, f3(1,2,3), f3(3,2,1), 8'(8'h90 + i));
         step();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      q.delete();
      ok = 1'b1;
      for (int i = 0; i < L + 2; i++) begin
         if (out_valid) ok = 1'b0;
         step();
      end
      check("rst_quiet", ok, 1'b1);
      drive(2'd1, f3(1,2,3), f3(4,5,6), 8'hA5);
      step();
      in_valid = 1'b0;
      wait_q(1, L + 10, "post_rst_count");
      repeat (L + 4) step();
      check("post_rst_only", q.size(), 1);
      if (q.size() > 0)
         check("post_rst_result", {q[0].c, q[0].tag}, {32'h42000000, 64'h0, 8'hA5});
      q.delete();

      // Boundary: accept and pop together at DEPTH-1
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH - 1; i++) begin
         drive(2'd3, f3(1,1,1), f3(2,2,2), 8'(8'hC0 + i));
         step();
      end
      in_valid = 1'b0;
      repeat (L + 2) step();
      check("bnd_ready_before", in_ready, 1'b1);
      drive(2'd3, f3(1,1,1), f3(2,2,2), 8'hCF);
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("bnd_ready_after", in_ready, 1'b1);
      acc = 0;
      for (int i = 0; i < 5; i++) begin
         drive(2'd3, f3(1,1,1), f3(2,2,2), 8'(8'hD0 + acc));
         rdy = in_ready;
         step();
         if (rdy) acc++;
      end
      in_valid = 1'b0;
      check("bnd_one_credit", acc, 1);
      out_ready = 1'b1;
      wait_q(DEPTH + 1, DEPTH + L + 20, "bnd_count");
      for (int i = 0; i < q.size() && i < DEPTH + 1; i++)
         check($sformatf("bnd_out%0d", i), {q[i].c, q[i].mode, q[i].tag},
               {96'h0, 2'd3, 8'(8'hC0 + i)});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vec3_product_pipe.md
# vec3_product_pipe

Pipelined, flow-controlled 3-vector product engine for the ray–triangle intersection datapath. Accepts two `p_float3` operands per transaction and computes one of three selectable products: cross, dot, or component-wise. The multiply and add cores are fixed-latency and cannot stall, so the block uses a credit-tracked output FIFO to provide full valid/ready backpressure. Each result carries a user tag, so edge, normal and determinant products can share one unit.

## Interface
- `MULT_LAT`, default 4: latency in cycles of the codebase `mult` core; ≥1.
- `ADD_LAT`, default 5: latency in cycles of the codebase `add` core; ≥1.
- `FIFO_DEPTH`, default 16: output buffer entries; power of two, ≥2.
- `TAG_W`, default 8: width of the pass-through tag.
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operand transaction valid.
- `in_ready` output 1: block can accept a transaction this cycle.
- `in_mode` input 2: 0 = cross, 1 = dot, 2 = component-wise; 3 is reserved.
- `in_a` input p_float3: operand a.
- `in_b` input p_float3: operand b.
- `in_tag` input TAG_W: opaque tag, returned unchanged with the result.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts the result.
- `out_c` output p_float3: result vector.
- `out_mode` output 2: mode of the transaction that produced `out_c`.
- `out_tag` output TAG_W: tag of that transaction.

## Operation
- **Accept rule:** a transaction is accepted when `in_valid && in_ready`. Exactly one accepted transaction enters the pipeline per cycle. There are no bubbles when accepts are back-to-back.
- **Pipeline shape:**
  - Stage M: six multiplies, `MULT_LAT` cycles.
  - Stage A1: three adds, `ADD_LAT` cycles.
  - Stage A2: one add, `ADD_LAT` cycles.
  - Total fixed latency `L = MULT_LAT + 2*ADD_LAT` for every mode.
- **Sideband:** valid, mode and tag travel down a shift register of length L alongside the data.
- **Cross (mode 0):** products are a.y·b.z, a.z·b.y, a.z·b.x, a.x·b.z, a.x·b.y, a.y·b.x.
  - A1 computes each difference by adding the negated second product. Negation is a sign-bit flip.
  - Results: c.x = a.y·b.z − a.z·b.y, c.y = a.z·b.x − a.x·b.z, c.z = a.x·b.y − a.y·b.x.
  - The A1 result is delayed `ADD_LAT` cycles to align with L.
- **Dot (mode 1):** multipliers compute a.x·b.x, a.y·b.y and a.z·b.z.
  - A1 computes s = a.x·b.x + a.y·b.y.
  - The a.z·b.z product is delayed `ADD_LAT` cycles.
  - A2 computes s + a.z·b.z.
  - Output: c.x = sum, c.y = c.z = +0.0.
- **Component-wise (mode 2):** c = (a.x·b.x, a.y·b.y, a.z·b.z), with the products delayed `2*ADD_LAT` cycles.
- **Reserved mode 3:** the transaction is accepted and flows through normally. Output is all-zero `out_c` with `out_mode` = 3.
- **Operand routing:** multiplier operands are muxed by mode in the issue cycle. The mode is registered with the data so that mixed-mode back-to-back streams stay correct.
- **Output FIFO:** stores {c, mode, tag} and is show-ahead. `out_c`, `out_mode` and `out_tag` are valid whenever `out_valid` = 1 and hold stable until popped.
- **Credit counter:** `cnt` = in-flight transactions + FIFO occupancy.
  - It increments on accept and decrements on pop (`out_valid && out_ready`).
  - Simultaneous accept and pop leave it unchanged.
  - `in_ready = (cnt < FIFO_DEPTH) && !rst`. This guarantees a FIFO write can never find the FIFO full.

## Timing
- **Reset:** while `rst` = 1, and on the cycle it deasserts, all of the following clear:
  - pipeline valid bits, FIFO pointers and `cnt`;
  - `out_valid` = 0, `in_ready` = 0, `out_c` = 0, `out_mode` = 0, `out_tag` = 0.
  - `in_ready` = 1 from the first cycle after `rst` falls.
- **Reset mid-operation:** all in-flight and buffered transactions are discarded. No result from before reset may ever appear after it.
- **Latency:** a transaction accepted in cycle t is written to the FIFO at the end of cycle t+L. `out_valid` rises in cycle t+L+1 if the FIFO was empty.
- **Throughput:** one result per cycle with `out_ready` held high.
- **FIFO boundaries:**
  - Full: `in_ready` = 0 exactly when `cnt` = `FIFO_DEPTH`.
  - Empty: `out_valid` = 0.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - Pop and write may occur in the same cycle at any occupancy, including empty (write only) and depth−1.
- **Ordering:** results leave strictly in acceptance order.

## Test plan
- Cross, a=(1,0,0) [0x3F800000,0,0], b=(0,1,0), tag 0x5A, accepted at cycle t → `out_valid` at t+L+1 with c=(0,0,1.0), tag 0x5A, mode 0.
- Dot, a=(1,2,3), b=(4,5,6) → c.x = 32.0 (0x42000000), c.y = c.z = 0; then component-wise with the same operands → (4.0, 10.0, 18.0).
- Mixed modes back-to-back: 3·L transactions accepted on consecutive cycles with modes cycling 0,1,2 and incrementing tags, `out_ready` = 1 → outputs on consecutive cycles, in order, each matching a software model.
- Backpressure: `out_ready` = 0 with `in_valid` held high → exactly `FIFO_DEPTH` accepts, then `in_ready` = 0. Raise `out_ready` → one pop per cycle, `in_ready` reasserts the cycle after the first pop, no loss or duplication.
- Reset mid-stream: assert `rst` for 1 cycle with 5 transactions in flight and 3 buffered → `out_valid` stays 0 for L+2 cycles after reset, and the next accepted transaction produces the only output.
- Boundary: `cnt` = `FIFO_DEPTH`−1 with simultaneous accept and pop → `cnt` unchanged and `in_ready` stays 1; reserved mode 3 → zero vector, `out_mode` = 3.
